hazard_forward_ctrl: RTL and testbench

- Data-hazard/forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Consumes the operand-use flags and NOP flag from the ID-stage decoder plus the rs1/rs2/rd fields.
- Keeps its own destination-tag pipeline for EX/MEM/WB and produces per-operand forward selects, the load-use stall, and an EX bubble.
- Counts stall cycles for performance monitoring.

---
 rtl/hazard_forward_if.sv | 36 +++
 rtl/hazard_forward_ctrl.sv | 88 ++++++++
 tb/tb_hazard_forward_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_if.sv
// ID-stage operand/destination fields into the hazard controller and the
// forward selects, stall and bubble controls back to the pipeline.
interface hazard_forward_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] RS1_ID;
  logic [REG_W-1:0] RS2_ID;
  logic [REG_W-1:0] RD_ID;
  logic             A_S_ID;
  logic             B_S_ID;
  logic             D_S_ID;
  logic             ID_NOP_ID;
  logic             RF_LE_ID;
  logic             L_ID;
  logic             FLUSH;
  logic             HOLD;
  logic [1:0]       FWD_A;
  logic [1:0]       FWD_B;
  logic [1:0]       FWD_D;
  logic             STALL;
  logic             NOP_EX;
  logic [CNT_W-1:0] STALL_CNT;

  modport master (
    output RS1_ID, RS2_ID, RD_ID, A_S_ID, B_S_ID, D_S_ID,
           ID_NOP_ID, RF_LE_ID, L_ID, FLUSH, HOLD,
    input  FWD_A, FWD_B, FWD_D, STALL, NOP_EX, STALL_CNT
  );

  modport slave (
    input  RS1_ID, RS2_ID, RD_ID, A_S_ID, B_S_ID, D_S_ID,
           ID_NOP_ID, RF_LE_ID, L_ID, FLUSH, HOLD,
    output FWD_A, FWD_B, FWD_D, STALL, NOP_EX, STALL_CNT
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Forwarding / load-use hazard controller: tracks EX/MEM/WB destination tags
// and resolves ID operands against them with zero-cycle latency.
module hazard_forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_forward_if.slave  bus
);

  logic             vld_p0, vld_p1, vld_p2;
  logic [REG_W-1:0] rd_p0, rd_p1, rd_p2;
  logic             ld_p0, ld_p1, ld_p2;
  logic [CNT_W-1:0] stall_cnt;

  logic [2:0] ex_hit, mem_hit, wb_hit;
  logic       load_use;
  logic       stall;
  logic       vld_nxt;

  function automatic logic tag_hit(input logic use_op, input logic [REG_W-1:0] src,
                                   input logic vld, input logic [REG_W-1:0] rd);
    return use_op && (src != '0) && vld && (rd == src);
  endfunction

  // An EX hit on a load cannot be forwarded yet; it stalls and selects the RF.
  function automatic logic [1:0] fwd_sel(input logic ex, input logic ex_ld,
                                         input logic mem, input logic wb);
    if (ex)  return ex_ld ? 2'b00 : 2'b01;
    if (mem) return 2'b10;
    if (wb)  return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign ex_hit[0]  = tag_hit(bus.A_S_ID, bus.RS1_ID, vld_p0, rd_p0);
  assign ex_hit[1]  = tag_hit(bus.B_S_ID, bus.RS2_ID, vld_p0, rd_p0);
  assign ex_hit[2]  = tag_hit(bus.D_S_ID, bus.RD_ID,  vld_p0, rd_p0);
  assign mem_hit[0] = tag_hit(bus.A_S_ID, bus.RS1_ID, vld_p1, rd_p1);
  assign mem_hit[1] = tag_hit(bus.B_S_ID, bus.RS2_ID, vld_p1, rd_p1);
  assign mem_hit[2] = tag_hit(bus.D_S_ID, bus.RD_ID,  vld_p1, rd_p1);
  assign wb_hit[0]  = tag_hit(bus.A_S_ID, bus.RS1_ID, vld_p2, rd_p2);
  assign wb_hit[1]  = tag_hit(bus.B_S_ID, bus.RS2_ID, vld_p2, rd_p2);
  assign wb_hit[2]  = tag_hit(bus.D_S_ID, bus.RD_ID,  vld_p2, rd_p2);

  assign load_use = (|ex_hit) & ld_p0;
  assign stall    = load_use & ~bus.FLUSH & ~bus.ID_NOP_ID;
  assign vld_nxt  = bus.RF_LE_ID & ~bus.ID_NOP_ID & ~stall & ~bus.FLUSH & (bus.RD_ID != '0);

  assign bus.FWD_A     = bus.ID_NOP_ID ? 2'b00 : fwd_sel(ex_hit[0], ld_p0, mem_hit[0], wb_hit[0]);
  assign bus.FWD_B     = bus.ID_NOP_ID ? 2'b00 : fwd_sel(ex_hit[1], ld_p0, mem_hit[1], wb_hit[1]);
  assign bus.FWD_D     = bus.ID_NOP_ID ? 2'b00 : fwd_sel(ex_hit[2], ld_p0, mem_hit[2], wb_hit[2]);
  assign bus.STALL     = stall;
  assign bus.NOP_EX    = stall | bus.FLUSH;
  assign bus.STALL_CNT = stall_cnt;

  // p0 = EX tag, p1 = MEM tag, p2 = WB tag; HOLD freezes the whole chain
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      rd_p0     <= '0;
      rd_p1     <= '0;
      rd_p2     <= '0;
      ld_p0     <= 1'b0;
      ld_p1     <= 1'b0;
      ld_p2     <= 1'b0;
      stall_cnt <= '0;
    end else if (!bus.HOLD) begin
      vld_p0 <= vld_nxt;
      rd_p0  <= bus.RD_ID;
      ld_p0  <= bus.L_ID;
      vld_p1 <= vld_p0;
      rd_p1  <= rd_p0;
      ld_p1  <= ld_p0;
      vld_p2 <= vld_p1;
      rd_p2  <= rd_p1;
      ld_p2  <= ld_p1;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for the hazard/forwarding controller: a sequential vector
// table plus reset-mid-stall and counter saturation sequences.
module tb_hazard_forward_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  hazard_forward_if #(.REG_W(5), .CNT_W(16)) bus ();
  hazard_forward_if #(.REG_W(5), .CNT_W(4))  sbus ();

  hazard_forward_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  hazard_forward_ctrl #(.REG_W(5), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .bus(sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        a, b, d, nop, le, ld, fl, hd;
    logic [1:0]  fa, fb, fd;
    logic        st, ne;
    logic [15:0] cnt;
    logic        chk_fa;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic a, input logic b, input logic d, input logic nop,
    input logic le, input logic ld, input logic fl, input logic hd,
    input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] fd,
    input logic st, input logic ne, input logic [15:0] cnt, input logic chk_fa);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.a = a; v.b = b; v.d = d; v.nop = nop;
    v.le = le; v.ld = ld; v.fl = fl; v.hd = hd;
    v.fa = fa; v.fb = fb; v.fd = fd;
    v.st = st; v.ne = ne; v.cnt = cnt; v.chk_fa = chk_fa;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.RS1_ID    = v.rs1;
    bus.RS2_ID    = v.rs2;
    bus.RD_ID     = v.rd;
    bus.A_S_ID    = v.a;
    bus.B_S_ID    = v.b;
    bus.D_S_ID    = v.d;
    bus.ID_NOP_ID = v.nop;
    bus.RF_LE_ID  = v.le;
    bus.L_ID      = v.ld;
    bus.FLUSH     = v.fl;
    bus.HOLD      = v.hd;
  endtask

  task automatic sdrive(input logic [4:0] rs1, input logic [4:0] rd,
                        input logic a, input logic le, input logic ld);
    sbus.RS1_ID    = rs1;
    sbus.RS2_ID    = 5'd0;
    sbus.RD_ID     = rd;
    sbus.A_S_ID    = a;
    sbus.B_S_ID    = 1'b0;
    sbus.D_S_ID    = 1'b0;
    sbus.ID_NOP_ID = 1'b0;
    sbus.RF_LE_ID  = le;
    sbus.L_ID      = ld;
    sbus.FLUSH     = 1'b0;
    sbus.HOLD      = 1'b0;
  endtask

  initial begin
    vec_t idle;
    logic [1:0] fa_got;
    total = 0;
    bad   = 0;

    //            rs1 rs2 rd  a b d nop le ld fl hd  fa fb fd st ne cnt chk
    tbl[0]  = mk(0,  0,  0,  0,0,0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(1,  2,  3,  1,1,0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(3,  0,  10, 1,0,0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(3,  0,  0,  1,0,0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(3,  0,  0,  1,0,0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(3,  0,  0,  1,0,0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(1,  0,  5,  1,0,0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(0,  5,  6,  1,1,0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 1);
    tbl[8]  = mk(0,  5,  6,  1,1,0, 0, 1, 0, 0, 0,  0, 2, 0, 0, 0, 1, 1);
    tbl[9]  = mk(0,  0,  7,  0,0,0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[10] = mk(0,  0,  7,  0,0,0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[11] = mk(7,  6,  0,  1,1,0, 0, 1, 0, 0, 0,  1, 3, 0, 0, 0, 1, 1);
    tbl[12] = mk(0,  7,  0,  1,1,0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 1, 1);
    tbl[13] = mk(0,  0,  9,  0,0,0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[14] = mk(2,  9,  9,  1,0,1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 1);
    tbl[15] = mk(0,  0,  4,  0,0,0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[16] = mk(4,  0,  8,  1,0,0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 1, 1, 0);
    tbl[17] = mk(8,  4,  0,  1,1,0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 1, 1);
    tbl[18] = mk(0,  0,  5,  0,0,0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[19] = mk(5,  0,  11, 1,0,0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 1, 1, 1);
    tbl[20] = mk(5,  0,  11, 1,0,0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 1, 1, 1);
    tbl[21] = mk(5,  0,  11, 1,0,0, 0, 1, 0, 0, 1,  0, 0, 0, 1, 1, 1, 1);
    tbl[22] = mk(5,  0,  11, 1,0,0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 1, 1);
    tbl[23] = mk(5,  0,  11, 1,0,0, 0, 1, 0, 0, 0,  2, 0, 0, 0, 0, 2, 1);
    tbl[24] = mk(11, 0,  12, 1,0,0, 0, 1, 0, 1, 1,  1, 0, 0, 0, 1, 2, 1);
    tbl[25] = mk(11, 5,  0,  1,1,0, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0, 2, 1);

    idle = mk(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,1);
    drive(idle);
    sdrive(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      fa_got = tbl[i].chk_fa ? bus.FWD_A : tbl[i].fa;
      check($sformatf("vec%0d", i),
            {38'd0, fa_got, bus.FWD_B, bus.FWD_D, bus.STALL, bus.NOP_EX, bus.STALL_CNT},
            {38'd0, tbl[i].fa, tbl[i].fb, tbl[i].fd, tbl[i].st, tbl[i].ne, tbl[i].cnt});
    end

    // reset asserted while a load-use stall is pending
    @(negedge clk);
    drive(mk(0,0,5, 0,0,0, 0,1,1,0,0, 0,0,0,0,0,0,1));
    @(negedge clk);
    drive(mk(5,0,0, 1,0,0, 0,0,0,0,0, 0,0,0,0,0,0,1));
    reset = 1'b1;
    #1;
    check("rst_pre_stall", {63'd0, bus.STALL}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    bus.FLUSH = 1'b1;
    #1;
    check("rst_post_out",
          {49'd0, bus.FWD_A, bus.FWD_B, bus.FWD_D, bus.STALL, bus.NOP_EX, bus.STALL_CNT},
          {49'd0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 16'd0});
    bus.FLUSH = 1'b0;
    #1;
    check("rst_nop_ex_follows_flush", {63'd0, bus.NOP_EX}, 64'd0);

    // saturation on a 4-bit counter instance: 20 stalls must stop at 15
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      sdrive(0, 5, 0, 1, 1);
      #1;
      if (k == 8) check("sat_mid_cnt", {60'd0, sbus.STALL_CNT}, 64'd8);
      @(negedge clk);
      sdrive(5, 0, 1, 0, 0);
      #1;
      check($sformatf("sat_stall%0d", k), {63'd0, sbus.STALL}, 64'd1);
    end
    @(negedge clk);
    sdrive(0, 0, 0, 0, 0);
    #1;
    check("sat_final_cnt", {60'd0, sbus.STALL_CNT}, 64'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
